// File: rtl/rvc_pkg.sv
// Shared RVC constants, packer FSM encoding and cache byte-order helper.
// Used by the write-side packer and the fetch-side aligner alike.
// Pure declarations; no logic or state.
package rvc_pkg;

   // Packer FSM: EMPTY = no pending halfword, HALF = low half held, PAD = flush owed
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_PAD   = 2'd2
   } pack_state_e;

   localparam logic [15:0] C_NOP = 16'h0001;

   // RV32I opcodes / funct3 values recognised by the compressor
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [2:0] F3_ADD   = 3'b000;
   localparam logic [2:0] F3_WORD  = 3'b010;

   // RVC quadrants and funct fields
   localparam logic [1:0] C_Q0      = 2'b00;
   localparam logic [1:0] C_Q1      = 2'b01;
   localparam logic [1:0] C_Q2      = 2'b10;
   localparam logic [2:0] C_F3_ADDI = 3'b000;
   localparam logic [2:0] C_F3_LI   = 3'b010;
   localparam logic [2:0] C_F3_LW   = 3'b010;
   localparam logic [2:0] C_F3_SW   = 3'b110;
   localparam logic [3:0] C_F4_MV   = 4'b1000;
   localparam logic [3:0] C_F4_ADD  = 4'b1001;

   // Logical word -> I-memory cache byte order (self-inverse)
   function automatic logic [31:0] cache_swap(input logic [31:0] p);
      return {p[7:0], p[15:8], p[23:16], p[31:24]};
   endfunction

endpackage

// File: rtl/rvc_packer_compressor.sv
// Maps one RV32I instruction onto its RVC form when it falls in the supported subset.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on whatever instruction is presented.
module rvc_compressor
   import rvc_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic        ok_o,
   output logic [15:0] c16_o
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [11:0] imm_i;
   logic [11:0] imm_s;
   logic        imm_fits6;
   logic        rd_c;
   logic        rs1_c;
   logic        rs2_c;

   assign opc   = instr_i[6:0];
   assign rd    = instr_i[11:7];
   assign f3    = instr_i[14:12];
   assign rs1   = instr_i[19:15];
   assign rs2   = instr_i[24:20];
   assign f7    = instr_i[31:25];
   assign imm_i = instr_i[31:20];
   assign imm_s = {instr_i[31:25], instr_i[11:7]};

   // 12-bit immediate is representable in 6 signed bits when [11:5] is all sign
   assign imm_fits6 = (&imm_i[11:5]) || !(|imm_i[11:5]);

   // Compressed register fields only reach x8..x15
   assign rd_c  = (rd[4:3]  == 2'b01);
   assign rs1_c = (rs1[4:3] == 2'b01);
   assign rs2_c = (rs2[4:3] == 2'b01);

   // Pattern-match the subset and build the 16-bit encoding
   always_comb begin
      ok_o  = 1'b0;
      c16_o = 16'h0000;
      if (instr_i != '0) begin
         if (opc == OP_IMM && f3 == F3_ADD && imm_fits6) begin
            if (rs1 == 5'd0 && rd != 5'd0) begin
               ok_o  = 1'b1;
               c16_o = {C_F3_LI, imm_i[5], rd, imm_i[4:0], C_Q1};
            end else if (rd == rs1 && rd != 5'd0 && imm_i != 12'd0) begin
               ok_o  = 1'b1;
               c16_o = {C_F3_ADDI, imm_i[5], rd, imm_i[4:0], C_Q1};
            end
         end else if (opc == OP_REG && f3 == F3_ADD && f7 == 7'd0 &&
                      rd != 5'd0 && rs2 != 5'd0) begin
            if (rs1 == 5'd0) begin
               ok_o  = 1'b1;
               c16_o = {C_F4_MV, rd, rs2, C_Q2};
            end else if (rs1 == rd) begin
               ok_o  = 1'b1;
               c16_o = {C_F4_ADD, rd, rs2, C_Q2};
            end
         end else if (opc == OP_LOAD && f3 == F3_WORD && rd_c && rs1_c &&
                      imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'd0) begin
            ok_o  = 1'b1;
            c16_o = {C_F3_LW, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], C_Q0};
         end else if (opc == OP_STORE && f3 == F3_WORD && rs2_c && rs1_c &&
                      imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'd0) begin
            ok_o  = 1'b1;
            c16_o = {C_F3_SW, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], C_Q0};
         end
      end
   end

endmodule

// File: rtl/rvc_packer.sv
// Packs a stream of RV32I instructions (RVC subset compressed) into 32-bit I-memory words.
// Latency: a word completed by an accepted input is valid the next cycle; no comb in->out path.
// Backpressure: single output register; input stalls while it is full and not draining, and in PAD.
module rvc_packer
   import rvc_pkg::*;
#(
   parameter int ADDR_W      = 30,
   parameter bit COMPRESS_EN = 1'b1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic              in_nocomp,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_word,
   output logic [ADDR_W-1:0] out_addr
);

   pack_state_e       state_q, state_d;
   logic [15:0]       pend_q, pend_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_word_q, out_word_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;

   logic              comp_ok;
   logic [15:0]       comp_c16;
   logic              use_c16;
   logic              out_free;
   logic              in_fire;
   logic              emit;
   logic [31:0]       emit_p;

   rvc_compressor u_comp (
      .instr_i (in_instr),
      .ok_o    (comp_ok),
      .c16_o   (comp_c16)
   );

   // PC-relative control flow is tagged in_nocomp so its offsets stay valid
   assign use_c16  = COMPRESS_EN && !in_nocomp && comp_ok;
   assign out_free = !out_valid_q || out_ready;
   assign in_ready = (state_q != ST_PAD) && out_free;
   assign in_fire  = in_valid && in_ready;

   assign out_valid = out_valid_q;
   assign out_word  = out_word_q;
   assign out_addr  = out_addr_q;

   // Next state: drain the output register, then optionally reload it with a new word
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      out_valid_d = out_valid_q;
      out_word_d  = out_word_q;
      out_addr_d  = out_addr_q;
      emit        = 1'b0;
      emit_p      = 32'h0;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_addr_d  = out_addr_q + ADDR_W'(1);
      end

      if (state_q == ST_PAD) begin
         if (out_free) begin
            emit    = 1'b1;
            emit_p  = {C_NOP, pend_q};
            state_d = ST_EMPTY;
         end
      end else if (in_fire) begin
         if (state_q == ST_EMPTY) begin
            if (use_c16) begin
               pend_d  = comp_c16;
               state_d = ST_HALF;
            end else begin
               emit   = 1'b1;
               emit_p = in_instr;
            end
         end else begin
            if (use_c16) begin
               emit    = 1'b1;
               emit_p  = {comp_c16, pend_q};
               state_d = ST_EMPTY;
            end else begin
               // 32-bit instruction straddles this word and the next
               emit   = 1'b1;
               emit_p = {in_instr[15:0], pend_q};
               pend_d = in_instr[31:16];
            end
         end
         // Final instruction left a halfword behind: pad it now, or defer if the slot is taken
         if (in_last && state_d == ST_HALF) begin
            if (emit) begin
               state_d = ST_PAD;
            end else begin
               emit    = 1'b1;
               emit_p  = {C_NOP, pend_d};
               state_d = ST_EMPTY;
            end
         end
      end

      if (emit) begin
         out_valid_d = 1'b1;
         out_word_d  = cache_swap(emit_p);
      end
   end

   // State and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         pend_q      <= 16'h0;
         out_valid_q <= 1'b0;
         out_word_q  <= 32'h0;
         out_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         out_word_q  <= out_word_d;
         out_addr_q  <= out_addr_d;
      end
   end

endmodule
